// File: rtl/register_bank_pkg.sv
// Shared KGP-RISC register-file definitions: widths, link register index and word/address types.
package register_bank_pkg;

  localparam int KGP_DATA_W   = 32;
  localparam int KGP_ADDR_W   = 5;
  localparam int KGP_NUM_REGS = 1 << KGP_ADDR_W;
  localparam int KGP_LINK_REG = 31;

  typedef logic [KGP_DATA_W-1:0] word_t;
  typedef logic [KGP_ADDR_W-1:0] reg_addr_t;

  // Read-port index in the top-level port-pair arrays.
  typedef enum logic {
    PORT_RS = 1'b0,
    PORT_RT = 1'b1
  } rd_port_e;

  localparam int KGP_NUM_RD_PORTS = 2;

endpackage

// File: rtl/register_bank_read_port.sv
// One asynchronous read port: array select, write-to-read forwarding and register-0 gating.
module register_bank_read_port
  import register_bank_pkg::*;
#(
  parameter int DATA_W        = KGP_DATA_W,
  parameter int ADDR_W        = KGP_ADDR_W,
  parameter int NUM_REGS      = 1 << ADDR_W,
  parameter int LINK_REG      = KGP_LINK_REG,
  parameter int HARDWIRE_ZERO = 0,
  parameter int BYPASS        = 1
) (
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] mem_i [NUM_REGS],
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              link_en_i,
  input  logic [DATA_W-1:0] link_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] array_word;
  logic              link_hit;
  logic              wr_hit;
  logic              zero_hit;

  assign array_word = mem_i[rd_addr_i];
  assign link_hit   = link_en_i && (rd_addr_i == LINK_ADDR);
  assign wr_hit     = wr_en_i && (rd_addr_i == wr_addr_i);
  assign zero_hit   = (HARDWIRE_ZERO != 0) && (rd_addr_i == '0);

  // Forwarding priority mirrors the storage block: the link write wins a collision.
  always_comb begin
    rd_data_o = array_word;
    if (BYPASS != 0) begin
      if (link_hit) begin
        rd_data_o = link_data_i;
      end else if (wr_hit) begin
        rd_data_o = wr_data_i;
      end
    end
    if (zero_hit) begin
      rd_data_o = '0;
    end
  end

endmodule

// File: rtl/register_bank.sv
// KGP-RISC 32x32 register file: two combinational read ports (rs, rt), one general write port
// and a dedicated link write port for call instructions.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int DATA_W        = KGP_DATA_W,
  parameter int ADDR_W        = KGP_ADDR_W,
  parameter int LINK_REG      = KGP_LINK_REG,
  parameter int HARDWIRE_ZERO = 0,
  parameter int BYPASS        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              link_en,
  input  logic [DATA_W-1:0] link_data
);

  localparam int                NUM_REGS  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              wr_ok;
  logic              link_ok;

  assign wr_ok   = wr_en && !((HARDWIRE_ZERO != 0) && (wr_addr == '0));
  assign link_ok = link_en && !((HARDWIRE_ZERO != 0) && (LINK_ADDR == '0));

  // The link write is issued last so it overrides a general write to the same index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        mem_q[wr_addr] <= wr_data;
      end
      if (link_ok) begin
        mem_q[LINK_ADDR] <= link_data;
      end
    end
  end

  logic [ADDR_W-1:0] rd_addr [KGP_NUM_RD_PORTS];
  logic [DATA_W-1:0] rd_data [KGP_NUM_RD_PORTS];

  assign rd_addr[PORT_RS] = rs_addr;
  assign rd_addr[PORT_RT] = rt_addr;
  assign rs_data          = rd_data[PORT_RS];
  assign rt_data          = rd_data[PORT_RT];

  genvar gi;
  generate
    for (gi = 0; gi < KGP_NUM_RD_PORTS; gi++) begin : g_rd_port
      register_bank_read_port #(
        .DATA_W        (DATA_W),
        .ADDR_W        (ADDR_W),
        .NUM_REGS      (NUM_REGS),
        .LINK_REG      (LINK_REG),
        .HARDWIRE_ZERO (HARDWIRE_ZERO),
        .BYPASS        (BYPASS)
      ) u_read_port (
        .rd_addr_i   (rd_addr[gi]),
        .mem_i       (mem_q),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .link_en_i   (link_en),
        .link_data_i (link_data),
        .rd_data_o   (rd_data[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: three variants (bypass, no bypass, hardwired zero) share stimulus.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, wr_addr;
  logic        wr_en, link_en;
  logic [31:0] wr_data, link_data;
  logic [31:0] rs_d [3];
  logic [31:0] rt_d [3];

  always #100 clk = ~clk;

  // unit 0: BYPASS=1 HARDWIRE_ZERO=0, unit 1: BYPASS=0, unit 2: HARDWIRE_ZERO=1
  register_bank #(.BYPASS(1), .HARDWIRE_ZERO(0)) dut_a (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_d[0]), .rt_data(rt_d[0]), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .link_en(link_en), .link_data(link_data));
  register_bank #(.BYPASS(0), .HARDWIRE_ZERO(0)) dut_b (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_d[1]), .rt_data(rt_d[1]), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .link_en(link_en), .link_data(link_data));
  register_bank #(.BYPASS(1), .HARDWIRE_ZERO(1)) dut_c (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_d[2]), .rt_data(rt_d[2]), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .link_en(link_en), .link_data(link_data));

  typedef struct {
    string       name;
    int          unit;
    bit          port;   // 0 = rs, 1 = rt
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  event chk_ev;

  task automatic expect_rd(input string name, input int unit, input bit port, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.unit = unit;
    e.port = port;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // Let combinational reads settle, then hand the queued expectations to the monitor.
  task automatic sample();
    #1;
    ->chk_ev;
    #1;
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    link_en = 1'b0;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = e.port ? rt_d[e.unit] : rs_d[e.unit];
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s unit%0d %s: got %h expected %h", e.name, e.unit, e.port ? "rt" : "rs", act, e.exp);
        end else begin
          $display("ok   %s unit%0d %s: %h", e.name, e.unit, e.port ? "rt" : "rs", act);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst = 1'b1; rs_addr = '0; rt_addr = 5'd17; wr_addr = '0;
    wr_en = 1'b0; link_en = 1'b0; wr_data = '0; link_data = '0;
    for (int u = 0; u < 3; u++) begin
      expect_rd("reset_rs0", u, 1'b0, 32'h0);
      expect_rd("reset_rt17", u, 1'b1, 32'h0);
    end
    sample();
    @(negedge clk);
    rst = 1'b0;

    // Test 1: fill regs 1..31, then asynchronous reset clears everything before the next edge.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'hA5A5_0000 + 32'(i);
    end
    @(negedge clk);
    idle();
    rs_addr = 5'd9; rt_addr = 5'd31;
    for (int u = 0; u < 3; u++) begin
      expect_rd("load_r9", u, 1'b0, 32'hA5A5_0009);
      expect_rd("load_r31", u, 1'b1, 32'hA5A5_001F);
    end
    sample();
    #20;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i);
      expect_rd($sformatf("async_rst_r%0d", i), 0, 1'b0, 32'h0);
      expect_rd($sformatf("async_rst_r%0d", 31 - i), 0, 1'b1, 32'h0);
      sample();
    end
    @(negedge clk);
    rst = 1'b0;

    // Test 2: write then read on both ports.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    idle();
    rs_addr = 5'd5; rt_addr = 5'd5;
    for (int u = 0; u < 3; u++) begin
      expect_rd("wr_rd_r5", u, 1'b0, 32'hDEAD_BEEF);
      expect_rd("wr_rd_r5", u, 1'b1, 32'hDEAD_BEEF);
    end
    sample();

    // Test 3: same-cycle bypass.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678; rt_addr = 5'd7; rs_addr = 5'd5;
    expect_rd("bypass_r7", 0, 1'b1, 32'h1234_5678);
    expect_rd("nobypass_old_r7", 1, 1'b1, 32'h0);
    expect_rd("bypass_r7", 2, 1'b1, 32'h1234_5678);
    expect_rd("bypass_other_r5", 0, 1'b0, 32'hDEAD_BEEF);
    sample();
    @(negedge clk);
    idle();
    expect_rd("nobypass_after_r7", 1, 1'b1, 32'h1234_5678);
    sample();

    // Test 4: collision on the link register, link wins.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h1111_1111;
    link_en = 1'b1; link_data = 32'h0000_0040; rs_addr = 5'd31; rt_addr = 5'd31;
    expect_rd("collide_bypass", 0, 1'b0, 32'h0000_0040);
    expect_rd("collide_nobypass_old", 1, 1'b0, 32'h0);
    expect_rd("collide_bypass", 2, 1'b1, 32'h0000_0040);
    sample();
    @(negedge clk);
    idle();
    for (int u = 0; u < 3; u++) expect_rd("collide_stored", u, 1'b0, 32'h0000_0040);
    sample();

    // Both ports writing different registers in one edge.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hCAFE_0010;
    link_en = 1'b1; link_data = 32'h0000_0044; rs_addr = 5'd10; rt_addr = 5'd31;
    expect_rd("dual_bypass_wr", 0, 1'b0, 32'hCAFE_0010);
    expect_rd("dual_bypass_link", 0, 1'b1, 32'h0000_0044);
    expect_rd("dual_nobypass_wr", 1, 1'b0, 32'h0);
    expect_rd("dual_nobypass_link", 1, 1'b1, 32'h0000_0040);
    sample();
    @(negedge clk);
    idle();
    for (int u = 0; u < 3; u++) begin
      expect_rd("dual_stored_wr", u, 1'b0, 32'hCAFE_0010);
      expect_rd("dual_stored_link", u, 1'b1, 32'h0000_0044);
    end
    sample();

    // Test 5: register 0 with and without hardwiring.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; rs_addr = 5'd0; rt_addr = 5'd0;
    expect_rd("r0_bypass", 0, 1'b0, 32'hFFFF_FFFF);
    expect_rd("r0_nobypass", 1, 1'b0, 32'h0);
    expect_rd("r0_hardwired", 2, 1'b0, 32'h0);
    expect_rd("r0_hardwired", 2, 1'b1, 32'h0);
    sample();
    @(negedge clk);
    idle();
    expect_rd("r0_stored", 0, 1'b0, 32'hFFFF_FFFF);
    expect_rd("r0_stored", 1, 1'b0, 32'hFFFF_FFFF);
    expect_rd("r0_hardwired_after", 2, 1'b0, 32'h0);
    sample();

    // Test 6: write pending while rst is high across an edge is discarded.
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0055; rs_addr = 5'd3; rt_addr = 5'd5;
    expect_rd("rst_hold_r3", 1, 1'b0, 32'h0);
    expect_rd("rst_hold_r5", 1, 1'b1, 32'h0);
    sample();
    @(negedge clk);
    rst = 1'b0;
    idle();
    for (int u = 0; u < 3; u++) begin
      expect_rd("rst_write_dropped_r3", u, 1'b0, 32'h0);
      expect_rd("rst_cleared_r5", u, 1'b1, 32'h0);
    end
    sample();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0066;
    @(negedge clk);
    idle();
    expect_rd("post_rst_write_r3", 1, 1'b0, 32'h0000_0066);
    sample();

    #5;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
